// File: rtl/ibuf_fill_ctl_pkg.sv
// Shared IFU constants and fill-FSM state encoding for the instruction buffer
// controller and the length/valid decode blocks.
package ibuf_fill_ctl_pkg;

    localparam int IBUF_DEPTH = 16;
    localparam int FILL_BYTES = 4;
    localparam int VLD_W      = 7;
    localparam int PTR_W      = $clog2(IBUF_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int LEN_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fill_state_t;

    // A new beat may only be requested when a full beat is guaranteed to fit.
    function automatic logic has_space(input logic [CNT_W-1:0] cnt);
        return cnt <= CNT_W'(IBUF_DEPTH - FILL_BYTES);
    endfunction

endpackage

// File: rtl/ibuf_occ_ptr.sv
// Instruction buffer read/write pointers, occupancy counter and top-of-buffer
// byte valid decode. Consumes larger than the occupancy are clamped.
module ibuf_occ_ptr
    import ibuf_fill_ctl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             flush,
    input  logic             consume,
    input  logic [LEN_W-1:0] consume_len,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] cnt,
    output logic [VLD_W-1:0] fetch_valid,
    output logic             empty
);

    logic [CNT_W-1:0] cnt_q;
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] take;

    always_comb begin
        take = '0;
        if (consume && !flush) begin
            take = (CNT_W'(consume_len) > cnt_q) ? cnt_q : CNT_W'(consume_len);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
        end else if (flush) begin
            // Redirect: drop everything, top of buffer restarts at the current write point.
            cnt_q <= '0;
            rd_q  <= wr_q;
        end else begin
            cnt_q <= cnt_q + (wr_en ? CNT_W'(FILL_BYTES) : '0) - take;
            rd_q  <= PTR_W'({1'b0, rd_q} + take);
            if (wr_en) begin
                wr_q <= wr_q + PTR_W'(FILL_BYTES);
            end
        end
    end

    always_comb begin
        fetch_valid = '0;
        for (int i = 0; i < VLD_W; i++) begin
            fetch_valid[i] = (cnt_q > CNT_W'(i));
        end
    end

    assign cnt    = cnt_q;
    assign wr_ptr = wr_q;
    assign rd_ptr = rd_q;
    assign empty  = (cnt_q == '0);

endmodule

// File: rtl/ibuf_fill_ctl.sv
// Instruction buffer fill/drain controller: ICU request FSM around the occupancy/pointer block.
// Optional checking of overconsume and stray ICU acks is enabled by IBUF_FILL_CTL_CHK_EN.
//
//  state      | meaning
//  ST_IDLE    | no request outstanding; request when a full beat fits
//  ST_REQ     | icu_req held; next ack is written into the buffer
//  ST_DISCARD | flushed while requesting; icu_req held, next ack is dropped
module ibuf_fill_ctl
    import ibuf_fill_ctl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    output logic             icu_req,
    input  logic             icu_ack,
    input  logic             iu_flush,
    input  logic             dec_consume,
    input  logic [LEN_W-1:0] dec_consume_len,
    output logic             ibuf_wr_en,
    output logic [PTR_W-1:0] ibuf_wr_ptr,
    output logic [PTR_W-1:0] ibuf_rd_ptr,
    output logic [VLD_W-1:0] fetch_valid,
    output logic [CNT_W-1:0] ibuf_cnt,
    output logic             ibuf_empty,
    output logic             ibuf_err
);

    fill_state_t state;

    assign ibuf_wr_en = (state == ST_REQ) && icu_ack && !iu_flush && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            icu_req <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!iu_flush && has_space(ibuf_cnt)) begin
                        state   <= ST_REQ;
                        icu_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (icu_ack) begin
                        state   <= ST_IDLE;
                        icu_req <= 1'b0;
                    end else if (iu_flush) begin
                        state <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (icu_ack) begin
                        state   <= ST_IDLE;
                        icu_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    icu_req <= 1'b0;
                end
            endcase
        end
    end

    ibuf_occ_ptr u_occ_ptr (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (ibuf_wr_en),
        .flush       (iu_flush),
        .consume     (dec_consume),
        .consume_len (dec_consume_len),
        .wr_ptr      (ibuf_wr_ptr),
        .rd_ptr      (ibuf_rd_ptr),
        .cnt         (ibuf_cnt),
        .fetch_valid (fetch_valid),
        .empty       (ibuf_empty)
    );

`ifdef IBUF_FILL_CTL_CHK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ibuf_err <= 1'b0;
        end else if ((dec_consume && !iu_flush && (CNT_W'(dec_consume_len) > ibuf_cnt)) ||
                     (icu_ack && (state == ST_IDLE))) begin
            ibuf_err <= 1'b1;
        end
    end
`else
    assign ibuf_err = 1'b0;
`endif

endmodule
